// File: rtl/alu_issue_ctrl.sv
// Issue/capture front end for the 64-bit combinational ALU: decodes op class + funct fields,
// registers operands/opcode, captures flags. Optional counters under ALU_ISSUE_PERF_EN.
module alu_issue_ctrl #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       alu_op_sel,
  input  logic [2:0]       funct3,
  input  logic             funct7_b5,
  input  logic [WIDTH-1:0] opnd_a,
  input  logic [WIDTH-1:0] opnd_b,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_op,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,
  input  logic             alu_overflow,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_zero,
  output logic             out_overflow,
`ifdef ALU_ISSUE_PERF_EN
  output logic [31:0]      perf_ops,
  output logic [31:0]      perf_ovf,
`endif
  output logic             out_illegal
);

  localparam logic [3:0] OP_AND  = 4'd0;
  localparam logic [3:0] OP_OR   = 4'd1;
  localparam logic [3:0] OP_ADD  = 4'd2;
  localparam logic [3:0] OP_SUB  = 4'd6;
  localparam logic [3:0] OP_SLT  = 4'd7;
  localparam logic [3:0] OP_NOR  = 4'd12;
  localparam logic [3:0] OP_NAND = 4'd13;

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t     state_q, state_d;
  logic [3:0] dec_op_p0;
  logic       dec_ill_p0;
  logic       acc_p0;

  // Returns {illegal, opcode}; funct7_b5 only matters for R-type funct3 000.
  function automatic logic [4:0] decode(input logic [1:0] sel, input logic [2:0] f3,
                                        input logic f7b5);
    logic [4:0] r;
    r = {1'b1, 4'd0};
    case (sel)
      2'b00: r = {1'b0, OP_ADD};
      2'b01: r = {1'b0, OP_SUB};
      2'b10: begin
        case (f3)
          3'b000:  r = {1'b0, (f7b5 ? OP_SUB : OP_ADD)};
          3'b111:  r = {1'b0, OP_AND};
          3'b110:  r = {1'b0, OP_OR};
          3'b010:  r = {1'b0, OP_SLT};
          default: r = {1'b1, 4'd0};
        endcase
      end
      default: begin
        case (f3)
          3'b000:  r = {1'b0, OP_NOR};
          3'b001:  r = {1'b0, OP_NAND};
          default: r = {1'b1, 4'd0};
        endcase
      end
    endcase
    return r;
  endfunction

  assign {dec_ill_p0, dec_op_p0} = decode(alu_op_sel, funct3, funct7_b5);
  assign acc_p0 = (state_q == IDLE) && in_valid;

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = dec_ill_p0 ? DONE : EXEC;
      end
      EXEC: state_d = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Stage p0 -> p1: accept registers ALU inputs; EXEC end captures ALU outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      alu_a        <= '0;
      alu_b        <= '0;
      alu_op       <= 4'd0;
      out_result   <= '0;
      out_zero     <= 1'b0;
      out_overflow <= 1'b0;
      out_illegal  <= 1'b0;
    end else begin
      if (acc_p0 && !dec_ill_p0) begin
        alu_a  <= opnd_a;
        alu_b  <= opnd_b;
        alu_op <= dec_op_p0;
      end else if (acc_p0) begin
        out_result   <= '0;
        out_zero     <= 1'b0;
        out_overflow <= 1'b0;
        out_illegal  <= 1'b1;
      end
      if (state_q == EXEC) begin
        out_result   <= alu_result;
        out_zero     <= alu_zero;
        out_overflow <= alu_overflow;
        out_illegal  <= 1'b0;
      end
    end
  end

`ifdef ALU_ISSUE_PERF_EN
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      perf_ops <= 32'd0;
      perf_ovf <= 32'd0;
    end else if (state_q == EXEC) begin
      perf_ops <= perf_ops + 32'd1;
      if (alu_overflow) perf_ovf <= perf_ovf + 32'd1;
    end
  end
`endif

endmodule
